// File: rtl/fb_pkg.sv
// fb_pkg: definitions shared by the frame-buffer port arbiter and the
// memory controller.
//   fbState_t   arbiter FSM states (IDLE / CMD / BUSY)
//   fbOwner_t   port owner encoding (OWN_RD=0, OWN_WR=1)
//   frameWords  number of words in one frame
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    BUSY = 2'd2
  } fbState_t;

  typedef enum logic {
    OWN_RD = 1'b0,
    OWN_WR = 1'b1
  } fbOwner_t;

  function automatic int frameWords(input int hAct, input int vAct);
    return hAct * vAct;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: request/grant and memory-command signals around the
// frame-buffer port arbiter.
//   master modport : the arbiter (drives o*, samples i*)
//   slave modport  : the FIFOs, VGA timing and memory controller
//   iTR_V / iWR_SOF            read / write frame-start pulses
//   iRD_REQ / iWR_REQ          burst requests (levels)
//   oRD_GNT / oWR_GNT          burst owns the port
//   oRD_ACK / oWR_ACK          burst finished pulses
//   oMEM_CMD_VALID / iMEM_CMD_READY / oMEM_CMD_WR / oMEM_ADDR   command
//   iMEM_DONE                  last word transferred pulse
//   oSTARVE                    write starvation limit reached
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 20
);
  logic              iTR_V;
  logic              iWR_SOF;
  logic              iRD_REQ;
  logic              iWR_REQ;
  logic              oRD_GNT;
  logic              oWR_GNT;
  logic              oRD_ACK;
  logic              oWR_ACK;
  logic              oMEM_CMD_VALID;
  logic              iMEM_CMD_READY;
  logic              oMEM_CMD_WR;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic              iMEM_DONE;
  logic              oSTARVE;

  modport master (
    input  iTR_V, iWR_SOF, iRD_REQ, iWR_REQ, iMEM_CMD_READY, iMEM_DONE,
    output oRD_GNT, oWR_GNT, oRD_ACK, oWR_ACK, oMEM_CMD_VALID, oMEM_CMD_WR,
           oMEM_ADDR, oSTARVE
  );

  modport slave (
    output iTR_V, iWR_SOF, iRD_REQ, iWR_REQ, iMEM_CMD_READY, iMEM_DONE,
    input  oRD_GNT, oWR_GNT, oRD_ACK, oWR_ACK, oMEM_CMD_VALID, oMEM_CMD_WR,
           oMEM_ADDR, oSTARVE
  );
endinterface

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: linear frame-buffer address counter for one side (read or
// write) with frame-start realignment.
//   iCLK, iRST   clock, async active-high reset
//   frameStart   one-cycle frame-start pulse for this side
//   midBurst     this side owns (or is being granted) the port
//   advance      this side's burst completes on this edge
//   addr         start address of this side's next burst
module fb_addr_gen #(
  parameter int ADDR_W      = 20,
  parameter int BURST       = 8,
  parameter int FRAME_WORDS = 307200
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              frameStart,
  input  logic              midBurst,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - BURST);

  logic pending;

  // A frame start during a burst cannot move the counter yet: the burst
  // already uses the old address and completing it would advance past 0.
  // It is remembered and applied on the burst's completion edge instead.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      addr    <= '0;
      pending <= 1'b0;
    end else if (advance) begin
      pending <= 1'b0;
      if (frameStart || pending || addr == LAST_ADDR) addr <= '0;
      else                                             addr <= addr + STEP;
    end else if (frameStart) begin
      if (midBurst) pending <= 1'b1;
      else          addr    <= '0;
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the frame-buffer memory port between the camera
// write path and the VGA read path, one whole burst at a time. Read wins
// ties unless the write starvation counter has reached STARVE_MAX.
//   iCLK, iRST   clock, async active-high reset
//   bus          fb_port_arbiter_if.master (requests, grants, acks,
//                memory command handshake, frame starts, starve flag)
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int BURST      = 8,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int STARVE_MAX = 64
) (
  input  logic                iCLK,
  input  logic                iRST,
  fb_port_arbiter_if.master   bus
);
  localparam int FRAME_WORDS = frameWords(H_ACT, V_ACT);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  if ((FRAME_WORDS % BURST) != 0 || (FRAME_WORDS >> ADDR_W) != 0 ||
      BURST < 2 || (BURST & (BURST - 1)) != 0 ||
      STARVE_MAX < 1 || STARVE_MAX > 255) begin : gBadParam
    $error("fb_port_arbiter: illegal BURST/frame/STARVE_MAX parameters");
  end

  fbState_t          state;
  fbOwner_t          owner;
  logic              rdGnt, wrGnt, rdAck, wrAck, cmdValid, cmdWr;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        starveCnt;
  logic [ADDR_W-1:0] rdAddr, wrAddr;

  logic grantRd, grantWr, finishing, wrOwns, rdMid, wrMid;

  always_comb begin
    grantWr   = (state == IDLE) && bus.iWR_REQ &&
                ((starveCnt >= STARVE_LIM) || !bus.iRD_REQ);
    grantRd   = (state == IDLE) && bus.iRD_REQ && !grantWr;
    finishing = (state == BUSY) && bus.iMEM_DONE;
    wrOwns    = (state != IDLE) && (owner == OWN_WR);
    // The grant edge counts as mid-burst: the command latches the old
    // address on that edge, so a frame start there must be deferred.
    rdMid     = ((state != IDLE) && (owner == OWN_RD)) || grantRd;
    wrMid     = wrOwns || grantWr;
  end

  fb_addr_gen #(.ADDR_W(ADDR_W), .BURST(BURST), .FRAME_WORDS(FRAME_WORDS)) uRdAddr (
    .iCLK(iCLK), .iRST(iRST), .frameStart(bus.iTR_V), .midBurst(rdMid),
    .advance(finishing && owner == OWN_RD), .addr(rdAddr)
  );

  fb_addr_gen #(.ADDR_W(ADDR_W), .BURST(BURST), .FRAME_WORDS(FRAME_WORDS)) uWrAddr (
    .iCLK(iCLK), .iRST(iRST), .frameStart(bus.iWR_SOF), .midBurst(wrMid),
    .advance(finishing && owner == OWN_WR), .addr(wrAddr)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      owner    <= OWN_RD;
      rdGnt    <= 1'b0;
      wrGnt    <= 1'b0;
      rdAck    <= 1'b0;
      wrAck    <= 1'b0;
      cmdValid <= 1'b0;
      cmdWr    <= 1'b0;
      memAddr  <= '0;
    end else begin
      rdAck <= 1'b0;
      wrAck <= 1'b0;
      case (state)
        IDLE: begin
          if (grantRd || grantWr) begin
            state    <= CMD;
            owner    <= grantWr ? OWN_WR : OWN_RD;
            rdGnt    <= grantRd;
            wrGnt    <= grantWr;
            cmdValid <= 1'b1;
            cmdWr    <= grantWr;
            memAddr  <= grantWr ? wrAddr : rdAddr;
          end
        end
        CMD: begin
          if (bus.iMEM_CMD_READY) begin
            state    <= BUSY;
            cmdValid <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.iMEM_DONE) begin
            state <= IDLE;
            rdGnt <= 1'b0;
            wrGnt <= 1'b0;
            rdAck <= (owner == OWN_RD);
            wrAck <= (owner == OWN_WR);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts cycles a pending write waits behind reads; saturates at the
  // limit so oSTARVE stays asserted until the write is granted.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                                                starveCnt <= '0;
    else if (grantWr)                                        starveCnt <= '0;
    else if (bus.iWR_REQ && !wrOwns && starveCnt < STARVE_LIM) starveCnt <= starveCnt + 8'd1;
  end

  assign bus.oRD_GNT        = rdGnt;
  assign bus.oWR_GNT        = wrGnt;
  assign bus.oRD_ACK        = rdAck;
  assign bus.oWR_ACK        = wrAck;
  assign bus.oMEM_CMD_VALID = cmdValid;
  assign bus.oMEM_CMD_WR    = cmdWr;
  assign bus.oMEM_ADDR      = memAddr;
  assign bus.oSTARVE        = (starveCnt == STARVE_LIM);
endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;
  localparam int AW = 20, B = 8, HA = 16, VA = 2, SM = 4, FW = HA * VA;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  fb_port_arbiter_if #(.ADDR_W(AW)) bus ();

  fb_port_arbiter #(.ADDR_W(AW), .BURST(B), .H_ACT(HA), .V_ACT(VA), .STARVE_MAX(SM)) dut (
    .iCLK(iCLK), .iRST(iRST), .bus(bus)
  );

  int nAssert = 0, nFail = 0;
  // Reference model: next burst address per side, deferred frame starts,
  // cycles a write has waited, and whether a write burst is in flight.
  int mRd, mWr, mCnt;
  bit mPendRd, mPendWr, mOwnWr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mRd = 0; mWr = 0; mCnt = 0; mPendRd = 0; mPendWr = 0; mOwnWr = 0;
  endtask

  // One clock edge; the waiting count follows the rule for that edge.
  task automatic tick(input bit grantWr);
    if (grantWr) mCnt = 0;
    else if (bus.iWR_REQ && !mOwnWr && mCnt < SM) mCnt++;
    @(posedge iCLK); #1;
  endtask

  task automatic chkIdleOut(input string tag);
    chk({tag, "_rdGnt"}, bus.oRD_GNT, 0);
    chk({tag, "_wrGnt"}, bus.oWR_GNT, 0);
    chk({tag, "_valid"}, bus.oMEM_CMD_VALID, 0);
    chk({tag, "_rdAck"}, bus.oRD_ACK, 0);
    chk({tag, "_wrAck"}, bus.oWR_ACK, 0);
  endtask

  // Full burst starting with the DUT idle and requests already driven.
  // d: cycles READY is held low; L: DONE latency after accept;
  // rdSofAt/wrSofAt: BUSY cycle index of a frame-start pulse (L = on DONE).
  task automatic burst(input int d, input int L, input int rdSofAt, input int wrSofAt);
    bit expWr, done;
    int expAddr;
    chk("starveFlag", bus.oSTARVE, (mCnt == SM));
    expWr   = bus.iWR_REQ && (mCnt >= SM || !bus.iRD_REQ);
    expAddr = expWr ? mWr : mRd;
    tick(expWr);
    mOwnWr = expWr;
    chk("cmdValid", bus.oMEM_CMD_VALID, 1);
    chk("rdGnt", bus.oRD_GNT, !expWr);
    chk("wrGnt", bus.oWR_GNT, expWr);
    chk("cmdWr", bus.oMEM_CMD_WR, expWr);
    chk("cmdAddr", bus.oMEM_ADDR, expAddr);
    chk("ackLow", {bus.oRD_ACK, bus.oWR_ACK}, 0);
    for (int i = 0; i < d; i++) begin
      bus.iMEM_DONE = (i == 0);        // stray DONE while waiting in CMD
      tick(0);
      bus.iMEM_DONE = 0;
      chk("holdValid", bus.oMEM_CMD_VALID, 1);
      chk("holdAddr", bus.oMEM_ADDR, expAddr);
      chk("holdWr", bus.oMEM_CMD_WR, expWr);
      chk("holdAck", {bus.oRD_ACK, bus.oWR_ACK}, 0);
    end
    bus.iMEM_CMD_READY = 1;
    tick(0);
    bus.iMEM_CMD_READY = 0;
    chk("acceptValid", bus.oMEM_CMD_VALID, 0);
    chk("busyGnt", {bus.oWR_GNT, bus.oRD_GNT}, expWr ? 2 : 1);
    for (int i = 0; i <= L; i++) begin
      done = (i == L);
      bus.iTR_V     = (rdSofAt == i);
      bus.iWR_SOF   = (wrSofAt == i);
      bus.iMEM_DONE = done;
      if (!done) begin
        if (bus.iTR_V)   begin if (!expWr) mPendRd = 1; else mRd = 0; end
        if (bus.iWR_SOF) begin if (expWr)  mPendWr = 1; else mWr = 0; end
      end else if (expWr) begin
        mWr = (mPendWr || bus.iWR_SOF) ? 0 : (mWr + B) % FW;
        mPendWr = 0;
        if (bus.iTR_V) mRd = 0;
      end else begin
        mRd = (mPendRd || bus.iTR_V) ? 0 : (mRd + B) % FW;
        mPendRd = 0;
        if (bus.iWR_SOF) mWr = 0;
      end
      tick(0);
      bus.iTR_V = 0; bus.iWR_SOF = 0; bus.iMEM_DONE = 0;
      if (!done) chk("busyNoAck", {bus.oRD_ACK, bus.oWR_ACK}, 0);
    end
    mOwnWr = 0;
    chk("rdAck", bus.oRD_ACK, !expWr);
    chk("wrAck", bus.oWR_ACK, expWr);
    chk("doneGnt", {bus.oRD_GNT, bus.oWR_GNT}, 0);
    chk("doneValid", bus.oMEM_CMD_VALID, 0);
  endtask

  initial begin
    int rq, d, L, rs, ws;
    iRST = 1;
    bus.iTR_V = 0; bus.iWR_SOF = 0; bus.iRD_REQ = 0; bus.iWR_REQ = 0;
    bus.iMEM_CMD_READY = 0; bus.iMEM_DONE = 0;
    modelReset();
    repeat (2) @(posedge iCLK);
    #1;
    chkIdleOut("reset");
    chk("reset_cmdWr", bus.oMEM_CMD_WR, 0);
    chk("reset_addr", bus.oMEM_ADDR, 0);
    chk("reset_starve", bus.oSTARVE, 0);
    @(negedge iCLK) iRST = 0;
    tick(0);
    chkIdleOut("idleNoReq");

    // Reads only: 0, 8, 16, 24, wrap to 0, 8.
    bus.iRD_REQ = 1;
    burst(0, 4, -1, -1);
    burst(0, 1, -1, -1);
    burst(0, 0, -1, -1);
    burst(1, 2, -1, -1);
    burst(0, 1, -1, -1);
    burst(0, 1, -1, -1);
    // Frame start during BUSY of the read at 16: next read at 0, not 24.
    burst(0, 3, 1, -1);
    burst(0, 1, -1, -1);
    // Frame start in IDLE realigns on the next edge.
    bus.iRD_REQ = 0;
    bus.iTR_V = 1; mRd = 0;
    tick(0);
    bus.iTR_V = 0;
    chkIdleOut("sofIdle");
    // DONE while idle is ignored.
    bus.iMEM_DONE = 1;
    tick(0);
    bus.iMEM_DONE = 0;
    chkIdleOut("strayDone");
    bus.iRD_REQ = 1;
    burst(0, 1, -1, -1);
    // READY backpressure.
    burst(5, 2, -1, -1);
    // Both requesting: reads until starved, then one write.
    bus.iWR_REQ = 1;
    repeat (8) burst(0, 0, -1, -1);

    // Randomized traffic, latencies and frame starts.
    for (int n = 0; n < 40; n++) begin
      rq = $urandom_range(1, 3);
      bus.iRD_REQ = rq[0];
      bus.iWR_REQ = rq[1];
      d = $urandom_range(0, 3);
      L = $urandom_range(0, 4);
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L) : -1;
      ws = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L) : -1;
      burst(d, L, rs, ws);
    end

    // Move the write counter off 0, then reset in the middle of a read.
    bus.iRD_REQ = 0; bus.iWR_REQ = 1;
    burst(0, 0, -1, -1);
    if (mWr == 0) burst(0, 0, -1, -1);
    bus.iRD_REQ = 1; bus.iWR_REQ = 0;
    tick(0);
    bus.iMEM_CMD_READY = 1;
    tick(0);
    bus.iMEM_CMD_READY = 0;
    tick(0);
    chk("preReset_gnt", bus.oRD_GNT, 1);
    #1 iRST = 1;
    #1;
    chkIdleOut("asyncReset");
    chk("asyncReset_addr", bus.oMEM_ADDR, 0);
    chk("asyncReset_starve", bus.oSTARVE, 0);
    bus.iRD_REQ = 0; bus.iWR_REQ = 1;
    modelReset();
    @(negedge iCLK) iRST = 0;
    burst(0, 2, -1, -1);
    chk("postReset_wrAddr", mWr, B);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single frame-buffer memory port between the camera write path and the VGA read path in the D8M loopback design. It grants whole bursts to one requester at a time, generates the linear frame-buffer address for each side, and realigns each address counter to frame start. Read has priority so the VGA line FIFO never underruns; a starvation counter guarantees write service. It sits between the camera/VGA FIFOs and the memory controller, and takes frame-start pulses from the VGA timing controller.

## Interface
- ADDR_W, 20, memory word address width
- BURST, 8, words per burst (power of two, ≥2)
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- STARVE_MAX, 64, write-wait cycles before write is forced ahead of read (1..255)

- iCLK  in  1  pixel/system clock, all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- iTR_V  in  1  read-frame start pulse, one cycle, from VGA timing
- iWR_SOF  in  1  write-frame start pulse, one cycle, from camera capture
- iRD_REQ  in  1  VGA FIFO has room for BURST words (level)
- iWR_REQ  in  1  camera FIFO holds ≥BURST words (level)
- oRD_GNT  out  1  read burst owns port (CMD through BUSY)
- oWR_GNT  out  1  write burst owns port
- oRD_ACK  out  1  one-cycle pulse, read burst finished
- oWR_ACK  out  1  one-cycle pulse, write burst finished
- oMEM_CMD_VALID  out  1  command valid to memory controller
- iMEM_CMD_READY  in  1  memory controller accepts command
- oMEM_CMD_WR  out  1  1 = write burst, 0 = read burst
- oMEM_ADDR  out  ADDR_W  burst start address
- iMEM_DONE  in  1  one-cycle pulse, last word of burst transferred
- oSTARVE  out  1  starvation counter at STARVE_MAX

## Operation
- FRAME_WORDS = H_ACT*V_ACT; must be a multiple of BURST and < 2**ADDR_W (elaboration check).
- Per-side address counters rd_addr, wr_addr, reset 0. On ACK they advance by BURST; if addr+BURST == FRAME_WORDS, they wrap to 0.
- Frame start (iTR_V → rd_addr, iWR_SOF → wr_addr): if that side is not mid-burst, addr ← 0 next edge. If mid-burst, a pending flag is set, and addr ← 0 on that side's ACK edge instead of advancing. Frame start on the ACK edge itself: addr ← 0.
- FSM states IDLE, CMD, BUSY.
  - IDLE: when the starve count is ≥ STARVE_MAX and iWR_REQ is high, grant write. Otherwise iRD_REQ grants read, and failing that iWR_REQ grants write. With no request, stay in IDLE.
  - On grant: go to CMD; latch owner, oMEM_CMD_WR, and oMEM_ADDR from that side's counter.
  - CMD: oMEM_CMD_VALID=1; command fields held stable until iMEM_CMD_READY. On ready, go to BUSY.
  - BUSY: wait for iMEM_DONE. Then pulse the owner's ACK, advance its address, and return to IDLE.
- iMEM_DONE outside BUSY is ignored.
- Starve counter, 8 bits, reset 0:
  - increments while iWR_REQ=1 and write is not the owner, saturating at STARVE_MAX;
  - cleared on the edge a write is granted;
  - held when iWR_REQ=0.
- oSTARVE = (count == STARVE_MAX).
- Request lines are sampled only in IDLE; a request dropping after grant does not abort the burst.

## Timing
- Reset values: state IDLE; all GNT/ACK/CMD_VALID/CMD_WR/STARVE outputs 0; oMEM_ADDR 0; counters and pending flags 0.
- iRST asserted mid-burst aborts immediately; the memory controller is reset by the same iRST.
- Request high in IDLE at edge N → GNT and CMD_VALID high from edge N+1 (registered outputs).
- With READY already high at N+1, BUSY is entered at N+2.
- iMEM_DONE at cycle M → ACK high for the cycle after edge M+1; GNT low and IDLE from the same edge. The earliest next grant is edge M+2.
- Minimum burst occupancy: 3 cycles plus memory latency. Back-to-back read bursts are separated by exactly one IDLE cycle.
- oMEM_ADDR and oMEM_CMD_WR change only on entry to CMD.

## Structure
- Shared package fb_pkg:
  - state enum (IDLE/CMD/BUSY);
  - FRAME_WORDS function;
  - owner encoding (OWN_RD=0, OWN_WR=1), reused by the memory controller.
- One sub-module, fb_addr_gen: a per-side address counter with a frame-start pending flag, instantiated twice (read, write).
- The FSM and starvation counter stay in the top level.

## Test plan
- Single read: iRD_REQ=1 from reset, READY=1, DONE 4 cycles after CMD accept → CMD at addr 0, WR=0; oRD_ACK one pulse; next read command at addr 8.
- Simultaneous requests: iRD_REQ=iWR_REQ=1 continuously, STARVE_MAX=4 → reads win until oSTARVE=1, then exactly one write at wr_addr 0; counter clears and reads resume.
- Wrap: H_ACT=16, V_ACT=2, BURST=8 → read addresses 0,8,16,24,0.
- Frame start mid-burst: iTR_V pulsed during BUSY of a read at addr 16 → the ACK edge sets rd_addr 0 (not 24); the next read command is at addr 0. iTR_V in IDLE resets on the next edge.
- READY backpressure: READY low 5 cycles in CMD → VALID, ADDR and WR held constant; BUSY entered the edge after READY rises.
- Reset mid-BUSY: iRST asserted → all outputs 0 asynchronously. After release with iWR_REQ=1, the first write is at addr 0.
